// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default widths, window size and the
// window-generator state type.
package cnn_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIM_W_DEF  = 16;
  localparam int MAX_W_DEF  = 256;
  localparam int WIN_K      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } win_state_e;

endpackage

// File: rtl/tile_window_gen_line_buf.sv
// One image line of storage: single write port, combinational read of the
// addressed entry (returns the value before the same-cycle write lands).
module line_buf
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = MAX_W_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

endmodule

// File: rtl/tile_window_gen.sv
// Raster pixel stream -> 3x3 sliding-window stream for one tile.
// Define TILE_WIN_STRIDE2_EN to add the cfg_stride2 port and stride-2 output decimation.
module tile_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int MAX_W  = MAX_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [DIM_W-1:0]                cfg_tile_in_h,
  input  logic [DIM_W-1:0]                cfg_tile_in_w,
`ifdef TILE_WIN_STRIDE2_EN
  input  logic                            cfg_stride2,
`endif
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIN_K*WIN_K*DATA_W-1:0]   out_win,
  output logic                            done
);

  localparam int AW   = $clog2(MAX_W);
  localparam int NWIN = WIN_K * WIN_K;

  win_state_e state_q, state_d;
  logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
  logic [DIM_W-1:0] h_q, h_d, w_q, w_d;
  logic out_valid_q, out_valid_d, done_q, done_d;
  logic [NWIN*DATA_W-1:0] out_win_q, out_win_d;
  logic [NWIN-1:0][DATA_W-1:0] win_q, win_d;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic accept, out_hs, last_px, emit, stride_ok;
`ifdef TILE_WIN_STRIDE2_EN
  logic stride2_q, stride2_d;
`endif

  assign in_ready  = (state_q == STREAM) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready && (state_q != IDLE);
  assign last_px   = (row_q == h_q - DIM_W'(1)) && (col_q == w_q - DIM_W'(1));
  assign out_valid = out_valid_q;
  assign out_win   = out_win_q;
  assign done      = done_q;

`ifdef TILE_WIN_STRIDE2_EN
  assign stride_ok = !stride2_q || (!row_q[0] && !col_q[0]);
`else
  assign stride_ok = 1'b1;
`endif
  assign emit = accept && (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2)) && stride_ok;

  // lb0 holds the previous row, lb1 the row before that, both indexed by column.
  line_buf #(.DATA_W(DATA_W), .DEPTH(MAX_W)) u_lb0 (
    .clk(clk), .we(accept), .addr(col_q[AW-1:0]), .wdata(in_data), .rdata(lb0_rd)
  );
  line_buf #(.DATA_W(DATA_W), .DEPTH(MAX_W)) u_lb1 (
    .clk(clk), .we(accept), .addr(col_q[AW-1:0]), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < WIN_K; r++) begin
        for (int c = 0; c < WIN_K - 1; c++) win_d[r*WIN_K+c] = win_q[r*WIN_K+c+1];
      end
      win_d[WIN_K-1]   = lb1_rd;
      win_d[2*WIN_K-1] = lb0_rd;
      win_d[NWIN-1]    = in_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    h_d         = h_q;
    w_d         = w_q;
    out_valid_d = out_valid_q;
    out_win_d   = out_win_q;
    done_d      = 1'b0;
`ifdef TILE_WIN_STRIDE2_EN
    stride2_d   = stride2_q;
`endif
    if (start) begin
      // Start also aborts any tile in flight, overriding same-cycle handshakes.
      state_d     = STREAM;
      row_d       = '0;
      col_d       = '0;
      h_d         = cfg_tile_in_h;
      w_d         = cfg_tile_in_w;
      out_valid_d = 1'b0;
`ifdef TILE_WIN_STRIDE2_EN
      stride2_d   = cfg_stride2;
`endif
    end else begin
      case (state_q)
        STREAM: begin
          if (out_hs) out_valid_d = 1'b0;
          if (accept) begin
            if (col_q == w_q - DIM_W'(1)) begin
              col_d = '0;
              row_d = row_q + DIM_W'(1);
            end else begin
              col_d = col_q + DIM_W'(1);
            end
            if (emit) begin
              out_valid_d = 1'b1;
              out_win_d   = win_d;
            end
            if (last_px) begin
              row_d = '0;
              col_d = '0;
              if (emit) begin
                state_d = DRAIN;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
            done_d      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      h_q         <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      out_win_q   <= '0;
      done_q      <= 1'b0;
`ifdef TILE_WIN_STRIDE2_EN
      stride2_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      h_q         <= h_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
      out_win_q   <= out_win_d;
      done_q      <= done_d;
`ifdef TILE_WIN_STRIDE2_EN
      stride2_q   <= stride2_d;
`endif
    end
  end

endmodule

// File: tb/tb_tile_window_gen.sv
// Bench for tile_window_gen: directed scenarios plus random tiles, checked every
// cycle against a window-list model derived from the tile's pixel array.
module tb_tile_window_gen;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_h = '0, cfg_w = '0;
`ifdef TILE_WIN_STRIDE2_EN
  logic        cfg_s = 1'b0;
`endif
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [71:0] out_win;
  logic        done;

  int checks = 0, errors = 0;
  logic [7:0]  pix [0:1023];
  int m_h = 0, m_w = 0, m_s = 0;
  logic [71:0] exp_q[$], hs_log[$], saved[$];
  int acc_cnt = 0, win_done = 0, win_total = 0, done_cnt = 0, acc_total = 0;
  int mon_r, mon_c;
  bit tile_active = 0, exp_valid_now = 0, exp_done_now = 0, stall_prev = 0;
  logic [71:0] stall_win = '0;

  always #5 clk = ~clk;

  tile_window_gen dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_tile_in_h(cfg_h), .cfg_tile_in_w(cfg_w),
`ifdef TILE_WIN_STRIDE2_EN
    .cfg_stride2(cfg_s),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
    .done(done)
  );

  task automatic chki(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chkw(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [71:0] lit9(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7,
                                       input int a8);
    int a [9];
    logic [71:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    r = '0;
    for (int k = 0; k < 9; k++) r[k*DW +: DW] = a[k][7:0];
    return r;
  endfunction

  // Every window of the tile, in raster order of its bottom-right pixel.
  task automatic build_expect();
    int step;
    logic [71:0] wv;
    exp_q.delete();
    step = (m_s != 0) ? 2 : 1;
    for (int r = 2; r < m_h; r += step)
      for (int c = 2; c < m_w; c += step) begin
        wv = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            wv[(3*i+j)*DW +: DW] = pix[(r-2+i)*m_w + (c-2+j)];
        exp_q.push_back(wv);
      end
    win_total = exp_q.size();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      tile_active   = 0;
      exp_q.delete();
      exp_valid_now = 0;
      exp_done_now  = 0;
      stall_prev    = 0;
    end else begin
      chki("done", int'(done), int'(exp_done_now));
      chki("in_ready", int'(in_ready),
           int'((tile_active && acc_cnt < m_h*m_w) && (!out_valid || out_ready)));
      if (exp_valid_now) chki("out_valid_rise", int'(out_valid), 1);
      if (stall_prev) begin
        chki("stall_valid", int'(out_valid), 1);
        chkw("stall_win", out_win, stall_win);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chki("spurious_valid", int'(out_valid), 0);
        else chkw("out_win", out_win, exp_q[0]);
      end
      exp_valid_now = 0;
      exp_done_now  = 0;
      stall_prev    = out_valid && !out_ready && !start;
      stall_win     = out_win;
      if (done) done_cnt++;
      if (start) begin
        build_expect();
        acc_cnt     = 0;
        win_done    = 0;
        tile_active = 1;
      end else if (tile_active) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() > 0) begin
            hs_log.push_back(out_win);
            exp_q.delete(0);
          end
          win_done++;
        end
        if (in_valid && in_ready) begin
          mon_r = acc_cnt / m_w;
          mon_c = acc_cnt % m_w;
          if (mon_r >= 2 && mon_c >= 2 && (m_s == 0 || (mon_r % 2 == 0 && mon_c % 2 == 0)))
            exp_valid_now = 1;
          acc_cnt++;
          acc_total++;
        end
        if (acc_cnt == m_h*m_w && win_done == win_total) begin
          exp_done_now = 1;
          tile_active  = 0;
        end
      end
    end
  end

  task automatic do_start(input int h, input int w, input int s);
    m_h = h; m_w = w; m_s = s;
    cfg_h = 16'(h);
    cfg_w = 16'(w);
`ifdef TILE_WIN_STRIDE2_EN
    cfg_s = 1'(s);
`endif
    hs_log.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_h = 16'($urandom);
    cfg_w = 16'($urandom);
`ifdef TILE_WIN_STRIDE2_EN
    cfg_s = ~cfg_s;
`endif
  endtask

  task automatic feed(input int limit, input int vprob, input int rprob, input bit hold5,
                      input bit stop_on_valid, input bit stop_at_limit, input int budget);
    int idx = 0, held = 0, cyc = 0;
    bit fin = 0;
    while (!fin && cyc < budget) begin
      in_valid = (idx < limit) && (int'($urandom_range(99)) < vprob);
      in_data  = pix[(idx < 1024) ? idx : 0];
      if (hold5) out_ready = !(out_valid && held < 5);
      else       out_ready = (int'($urandom_range(99)) < rprob);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (hold5 && out_valid && !out_ready) held++;
      if (done) fin = 1;
      if (stop_on_valid && out_valid) fin = 1;
      if (stop_at_limit && idx == limit) fin = 1;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chki("feed_timeout", int'(fin), 1);
    if (hold5) chki("hold_cycles", held, 5);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid  = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int d0, a0, h, w, s;
    repeat (3) @(posedge clk);
    #1;
    chki("rst_in_ready", int'(in_ready), 0);
    chki("rst_out_valid", int'(out_valid), 0);
    chkw("rst_out_win", out_win, '0);
    chki("rst_done", int'(done), 0);
    rst = 1'b0;
    idle(3);

    // 4x4 ramp, stride 1, always ready
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    d0 = done_cnt;
    do_start(4, 4, 0);
    feed(16, 100, 100, 0, 0, 0, 500);
    chki("ramp_count", hs_log.size(), 4);
    if (hs_log.size() == 4) begin
      chkw("ramp_first", hs_log[0], lit9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      chkw("ramp_last", hs_log[3], lit9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    end
    saved = hs_log;
    idle(4);
    chki("ramp_done_cnt", done_cnt - d0, 1);

    // same tile with the first window stalled for 5 cycles
    do_start(4, 4, 0);
    feed(16, 100, 100, 1, 0, 0, 500);
    chki("stall_count", hs_log.size(), saved.size());
    for (int k = 0; k < hs_log.size() && k < saved.size(); k++)
      chkw("stall_same", hs_log[k], saved[k]);
    idle(4);

`ifdef TILE_WIN_STRIDE2_EN
    for (int i = 0; i < 25; i++) pix[i] = 8'(i);
    do_start(5, 5, 1);
    feed(25, 100, 100, 0, 0, 0, 500);
    chki("s2_count", hs_log.size(), 4);
    if (hs_log.size() == 4) begin
      chki("s2_c0", int'(hs_log[0][4*DW +: DW]), 6);
      chki("s2_c1", int'(hs_log[1][4*DW +: DW]), 8);
      chki("s2_c2", int'(hs_log[2][4*DW +: DW]), 16);
      chki("s2_c3", int'(hs_log[3][4*DW +: DW]), 18);
    end
    idle(4);
`endif

    // 2x5 tile: pixels consumed, no windows, one done
    for (int i = 0; i < 10; i++) pix[i] = 8'($urandom);
    d0 = done_cnt; a0 = acc_total;
    do_start(2, 5, 0);
    feed(10, 80, 100, 0, 0, 0, 500);
    idle(4);
    chki("thin_accepts", acc_total - a0, 10);
    chki("thin_windows", hs_log.size(), 0);
    chki("thin_done_cnt", done_cnt - d0, 1);

    // abort after 7 pixels, then a 3x3 tile
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    d0 = done_cnt;
    do_start(4, 4, 0);
    feed(7, 100, 100, 0, 0, 1, 200);
    for (int i = 0; i < 9; i++) pix[i] = 8'(100 + i);
    do_start(3, 3, 0);
    feed(9, 100, 100, 0, 0, 0, 300);
    idle(4);
    chki("abort_count", hs_log.size(), 1);
    if (hs_log.size() == 1)
      chkw("abort_win", hs_log[0], lit9(100, 101, 102, 103, 104, 105, 106, 107, 108));
    chki("abort_done_cnt", done_cnt - d0, 1);

    // reset while a window is waiting
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    d0 = done_cnt;
    do_start(4, 4, 0);
    feed(16, 100, 0, 0, 1, 0, 300);
    chki("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chki("arst_out_valid", int'(out_valid), 0);
    chki("arst_in_ready", int'(in_ready), 0);
    chki("arst_done", int'(done), 0);
    chkw("arst_out_win", out_win, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    for (int i = 0; i < 9; i++) pix[i] = 8'(100 + i);
    do_start(3, 3, 0);
    feed(9, 100, 100, 0, 0, 0, 300);
    idle(4);
    chki("post_rst_count", hs_log.size(), 1);
    if (hs_log.size() == 1)
      chkw("post_rst_win", hs_log[0], lit9(100, 101, 102, 103, 104, 105, 106, 107, 108));
    chki("post_rst_done_cnt", done_cnt - d0, 1);

    // random tiles with random valid/ready throttling
    for (int t = 0; t < 12; t++) begin
      h = int'($urandom_range(7, 1));
      w = int'($urandom_range(9, 1));
      s = 0;
`ifdef TILE_WIN_STRIDE2_EN
      s = int'($urandom_range(1));
`endif
      for (int i = 0; i < h*w; i++) pix[i] = 8'($urandom);
      d0 = done_cnt;
      do_start(h, w, s);
      feed(h*w, int'($urandom_range(100, 50)), int'($urandom_range(100, 30)), 0, 0, 0, 3000);
      idle(3);
      chki("rand_done_cnt", done_cnt - d0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
